// File: rtl/polar_to_iq_if.sv
// Handshake bundle for polar_to_iq: polar request in, rectangular result out.
// The master drives requests and out_ready; the slave is the converter.
interface polar_to_iq_if #(
    parameter int MAG_W = 15,
    parameter int OUT_W = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [MAG_W-1:0]        mag_in;
    logic [15:0]             phase_in;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] re_out;
    logic signed [OUT_W-1:0] im_out;
    logic                    out_err;

    modport master (
        output in_valid, mag_in, phase_in, out_ready,
        input  in_ready, out_valid, re_out, im_out, out_err
    );

    modport slave (
        input  in_valid, mag_in, phase_in, out_ready,
        output in_ready, out_valid, re_out, im_out, out_err
    );
endinterface

// File: rtl/polar_to_iq.sv
// Polar (magnitude, phase in 0.1 deg) to signed I/Q converter.
// Quarter-wave sine table with linear interpolation; one result in flight at a time.
module polar_to_iq #(
    parameter int MAG_W = 15,
    parameter int OUT_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    polar_to_iq_if.slave  bus
);
    localparam int PROD_W = MAG_W + 15;

    typedef enum logic [2:0] {
        IDLE, FOLD, INDEX, LOOKUP, INTERP, SCALE, HOLD
    } state_t;

    state_t                  state_q, state_d;
    logic [MAG_W-1:0]        mag_q;
    logic [15:0]             phase_q;
    logic [1:0]              quad_q;
    logic [9:0]              p_q, pc_q;
    logic signed [OUT_W-1:0] re_q, im_q;
    logic                    err_q;

    logic                    phase_bad;
    logic [1:0]              quad_d;
    logic [9:0]              p_d, pc_d;
    logic [MAG_W-1:0]        sa_w, ca_w;
    logic signed [OUT_W-1:0] sa_s, ca_s, re_d, im_d;
    logic                    in_ready_w, out_valid_w;

    // Channel 0 carries the sine offset p, channel 1 the complementary offset pc.
    logic [9:0]              x_w [2];
    logic [14:0]             v_w [2];

    // round(32767*sin(k deg)), k = 0..90
    function automatic logic [14:0] lut_val(input logic [6:0] k);
        case (k)
            7'd0:  lut_val = 15'd0;      7'd1:  lut_val = 15'd572;
            7'd2:  lut_val = 15'd1144;   7'd3:  lut_val = 15'd1715;
            7'd4:  lut_val = 15'd2286;   7'd5:  lut_val = 15'd2856;
            7'd6:  lut_val = 15'd3425;   7'd7:  lut_val = 15'd3993;
            7'd8:  lut_val = 15'd4560;   7'd9:  lut_val = 15'd5126;
            7'd10: lut_val = 15'd5690;   7'd11: lut_val = 15'd6252;
            7'd12: lut_val = 15'd6813;   7'd13: lut_val = 15'd7371;
            7'd14: lut_val = 15'd7927;   7'd15: lut_val = 15'd8481;
            7'd16: lut_val = 15'd9032;   7'd17: lut_val = 15'd9580;
            7'd18: lut_val = 15'd10126;  7'd19: lut_val = 15'd10668;
            7'd20: lut_val = 15'd11207;  7'd21: lut_val = 15'd11743;
            7'd22: lut_val = 15'd12275;  7'd23: lut_val = 15'd12803;
            7'd24: lut_val = 15'd13328;  7'd25: lut_val = 15'd13848;
            7'd26: lut_val = 15'd14364;  7'd27: lut_val = 15'd14876;
            7'd28: lut_val = 15'd15383;  7'd29: lut_val = 15'd15886;
            7'd30: lut_val = 15'd16384;  7'd31: lut_val = 15'd16876;
            7'd32: lut_val = 15'd17364;  7'd33: lut_val = 15'd17846;
            7'd34: lut_val = 15'd18323;  7'd35: lut_val = 15'd18794;
            7'd36: lut_val = 15'd19260;  7'd37: lut_val = 15'd19720;
            7'd38: lut_val = 15'd20173;  7'd39: lut_val = 15'd20621;
            7'd40: lut_val = 15'd21062;  7'd41: lut_val = 15'd21497;
            7'd42: lut_val = 15'd21925;  7'd43: lut_val = 15'd22347;
            7'd44: lut_val = 15'd22762;  7'd45: lut_val = 15'd23170;
            7'd46: lut_val = 15'd23571;  7'd47: lut_val = 15'd23964;
            7'd48: lut_val = 15'd24351;  7'd49: lut_val = 15'd24730;
            7'd50: lut_val = 15'd25101;  7'd51: lut_val = 15'd25465;
            7'd52: lut_val = 15'd25821;  7'd53: lut_val = 15'd26169;
            7'd54: lut_val = 15'd26509;  7'd55: lut_val = 15'd26841;
            7'd56: lut_val = 15'd27165;  7'd57: lut_val = 15'd27481;
            7'd58: lut_val = 15'd27788;  7'd59: lut_val = 15'd28087;
            7'd60: lut_val = 15'd28377;  7'd61: lut_val = 15'd28659;
            7'd62: lut_val = 15'd28932;  7'd63: lut_val = 15'd29196;
            7'd64: lut_val = 15'd29451;  7'd65: lut_val = 15'd29697;
            7'd66: lut_val = 15'd29934;  7'd67: lut_val = 15'd30162;
            7'd68: lut_val = 15'd30381;  7'd69: lut_val = 15'd30591;
            7'd70: lut_val = 15'd30791;  7'd71: lut_val = 15'd30982;
            7'd72: lut_val = 15'd31163;  7'd73: lut_val = 15'd31335;
            7'd74: lut_val = 15'd31498;  7'd75: lut_val = 15'd31650;
            7'd76: lut_val = 15'd31794;  7'd77: lut_val = 15'd31927;
            7'd78: lut_val = 15'd32051;  7'd79: lut_val = 15'd32165;
            7'd80: lut_val = 15'd32269;  7'd81: lut_val = 15'd32364;
            7'd82: lut_val = 15'd32448;  7'd83: lut_val = 15'd32523;
            7'd84: lut_val = 15'd32587;  7'd85: lut_val = 15'd32642;
            7'd86: lut_val = 15'd32687;  7'd87: lut_val = 15'd32722;
            7'd88: lut_val = 15'd32747;  7'd89: lut_val = 15'd32762;
            7'd90: lut_val = 15'd32767;
            default: lut_val = 15'd0;
        endcase
    endfunction

    // Quadrant fold; p and pc are only meaningful when the phase is legal.
    always_comb begin
        phase_bad = (phase_q > 16'd3599);
        quad_d    = 2'd0;
        p_d       = 10'(phase_q);
        if (phase_q >= 16'd2700) begin
            quad_d = 2'd3;
            p_d    = 10'(phase_q - 16'd2700);
        end else if (phase_q >= 16'd1800) begin
            quad_d = 2'd2;
            p_d    = 10'(phase_q - 16'd1800);
        end else if (phase_q >= 16'd900) begin
            quad_d = 2'd1;
            p_d    = 10'(phase_q - 16'd900);
        end
        pc_d = 10'd900 - p_d;
    end

    assign x_w[0] = p_q;
    assign x_w[1] = pc_q;

    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        logic [6:0]  idx_q;
        logic [3:0]  frac_q;
        logic [14:0] lo_q, hi_q, val_q;
        logic [6:0]  idx_d, idx_hi;
        logic [3:0]  frac_d;
        logic [14:0] val_d;

        // x*6554>>16 is floor(x/10) for every x up to 900, so no divider is needed.
        always_comb begin
            idx_d  = 7'((23'(x_w[gi]) * 23'd6554) >> 16);
            frac_d = 4'(x_w[gi] - 10'(idx_d) * 10'd10);
            idx_hi = (idx_q >= 7'd90) ? 7'd90 : idx_q + 7'd1;
            val_d  = lo_q + 15'(((23'(hi_q) - 23'(lo_q)) * 23'(frac_q) * 23'd205) >> 11);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                idx_q  <= '0;
                frac_q <= '0;
                lo_q   <= '0;
                hi_q   <= '0;
                val_q  <= '0;
            end else begin
                case (state_q)
                    INDEX: begin
                        idx_q  <= idx_d;
                        frac_q <= frac_d;
                    end
                    LOOKUP: begin
                        lo_q <= lut_val(idx_q);
                        hi_q <= lut_val(idx_hi);
                    end
                    INTERP:  val_q <= val_d;
                    default: ;
                endcase
            end
        end

        assign v_w[gi] = val_q;
    end

    // Scale by magnitude, then place sine/cosine magnitudes by quadrant.
    always_comb begin
        sa_w = MAG_W'((PROD_W'(mag_q) * PROD_W'(v_w[0])) >> 15);
        ca_w = MAG_W'((PROD_W'(mag_q) * PROD_W'(v_w[1])) >> 15);
        sa_s = OUT_W'(sa_w);
        ca_s = OUT_W'(ca_w);
        re_d = ca_s;
        im_d = sa_s;
        case (quad_q)
            2'd1: begin re_d = -sa_s; im_d =  ca_s; end
            2'd2: begin re_d = -ca_s; im_d = -sa_s; end
            2'd3: begin re_d =  sa_s; im_d = -ca_s; end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        in_ready_w  = 1'b0;
        out_valid_w = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_w = 1'b1;
                if (bus.in_valid) state_d = FOLD;
            end
            FOLD:   state_d = phase_bad ? HOLD : INDEX;
            INDEX:  state_d = LOOKUP;
            LOOKUP: state_d = INTERP;
            INTERP: state_d = SCALE;
            SCALE:  state_d = HOLD;
            HOLD: begin
                out_valid_w = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mag_q   <= '0;
            phase_q <= '0;
            quad_q  <= '0;
            p_q     <= '0;
            pc_q    <= '0;
            re_q    <= '0;
            im_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        mag_q   <= bus.mag_in;
                        phase_q <= bus.phase_in;
                    end
                end
                FOLD: begin
                    quad_q <= quad_d;
                    p_q    <= p_d;
                    pc_q   <= pc_d;
                    err_q  <= phase_bad;
                    if (phase_bad) begin
                        re_q <= '0;
                        im_q <= '0;
                    end
                end
                SCALE: begin
                    re_q <= re_d;
                    im_q <= im_d;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.re_out    = re_q;
    assign bus.im_out    = im_q;
    assign bus.out_err   = err_q;
endmodule

// File: tb/tb_polar_to_iq.sv
// Directed and swept checks of polar_to_iq against hand-computed and trig reference values.
module tb_polar_to_iq;
    localparam int MAG_W = 15;
    localparam int OUT_W = 16;
    localparam int NV    = 11;
    localparam real PI   = 3.14159265358979;

    localparam int VEC_MAG [NV] = '{32767, 32767, 32767, 32767, 32767, 32767, 20000, 32767, 1000, 0, 1000};
    localparam int VEC_PH  [NV] = '{0, 900, 1800, 2700, 300, 15, 1234, 3599, 3600, 1234, 65535};
    localparam int VEC_RE  [NV] = '{32766, 0, -32766, 0, 28376, 32753, -11008, 32765, 0, 0, 0};
    localparam int VEC_IM  [NV] = '{0, 32766, 0, -32766, 16383, 857, 16695, -56, 0, 0, 0};
    localparam int VEC_ERR [NV] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1};
    localparam int VEC_LAT [NV] = '{6, 6, 6, 6, 6, 6, 6, 6, 2, 6, 2};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    polar_to_iq_if #(.MAG_W(MAG_W), .OUT_W(OUT_W)) bus ();

    polar_to_iq #(.MAG_W(MAG_W), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input int obs, input int exp, input int tol = 0);
        n_vec++;
        if ((obs - exp > tol) || (exp - obs > tol)) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d) at %0t", tag, obs, exp, tol, $time);
        end
    endtask

    // Present a request, let it be accepted, and count cycles until out_valid.
    task automatic apply(input int mag, input int ph, output int lat);
        int g;
        bus.mag_in   = MAG_W'(mag);
        bus.phase_in = 16'(ph);
        bus.in_valid = 1'b1;
        g = 0;
        while (!bus.in_ready && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 20) check_val("accept_timeout", g, 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got %0d vectors", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int hv;
        int exp_re;
        int exp_im;
        real ang;

        bus.in_valid  = 1'b0;
        bus.mag_in    = '0;
        bus.phase_in  = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ready",  int'(bus.in_ready),  1);
        check_val("rst_out_valid", int'(bus.out_valid), 0);
        check_val("rst_re",        int'(bus.re_out),    0);
        check_val("rst_im",        int'(bus.im_out),    0);
        check_val("rst_err",       int'(bus.out_err),   0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < NV; k++) begin
            apply(VEC_MAG[k], VEC_PH[k], lat);
            check_val("latency", lat, VEC_LAT[k]);
            check_val("re",  int'(bus.re_out),  VEC_RE[k]);
            check_val("im",  int'(bus.im_out),  VEC_IM[k]);
            check_val("err", int'(bus.out_err), VEC_ERR[k]);
            $display("vec %0d mag=%0d phase=%0d -> re=%0d im=%0d err=%0d lat=%0d",
                     k, VEC_MAG[k], VEC_PH[k], bus.re_out, bus.im_out, bus.out_err, lat);
            release_out();
        end

        // Backpressure: result held while a new request waits on in_valid.
        apply(32767, 300, lat);
        check_val("bp_latency", lat, 6);
        bus.mag_in   = 15'd32767;
        bus.phase_in = 16'd1800;
        bus.in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check_val("bp_out_valid", int'(bus.out_valid), 1);
            check_val("bp_in_ready",  int'(bus.in_ready),  0);
            check_val("bp_re",        int'(bus.re_out),    28376);
            check_val("bp_im",        int'(bus.im_out),    16383);
        end
        bus.out_ready = 1'b1;
        check_val("bp_in_ready_at_release", int'(bus.in_ready), 0);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check_val("bp_in_ready_after", int'(bus.in_ready),  1);
        check_val("bp_valid_dropped",  int'(bus.out_valid), 0);
        apply(32767, 1800, lat);
        check_val("bp2_latency", lat, 6);
        check_val("bp2_re", int'(bus.re_out), -32766);
        check_val("bp2_im", int'(bus.im_out), 0);
        $display("backpressure mag=32767 phase=1800 -> re=%0d im=%0d lat=%0d", bus.re_out, bus.im_out, lat);
        release_out();

        // Reset while in INTERP discards the in-flight result.
        bus.mag_in   = 15'd32767;
        bus.phase_in = 16'd900;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_in_ready",  int'(bus.in_ready),  1);
        check_val("mid_rst_out_valid", int'(bus.out_valid), 0);
        check_val("mid_rst_re",        int'(bus.re_out),    0);
        check_val("mid_rst_im",        int'(bus.im_out),    0);
        check_val("mid_rst_err",       int'(bus.out_err),   0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        hv = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.out_valid) hv++;
        end
        check_val("no_result_after_rst", hv, 0);
        $display("reset in INTERP -> out_valid cycles=%0d re=%0d im=%0d", hv, bus.re_out, bus.im_out);

        // Full-circle sweep against floating-point trig.
        for (int ph = 0; ph < 3600; ph++) begin
            if (n_err <= 20) begin
                apply(32767, ph, lat);
                ang    = real'(ph) * PI / 1800.0;
                exp_re = int'(32767.0 * $cos(ang));
                exp_im = int'(32767.0 * $sin(ang));
                check_val("sweep_latency", lat, 6);
                check_val("sweep_re", int'(bus.re_out), exp_re, 3);
                check_val("sweep_im", int'(bus.im_out), exp_im, 3);
                release_out();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
